eliminate: RTL and testbench

Resolves the board after a successful swap: finds every horizontal or vertical run of three or more equal gems, clears them, drops gems down under gravity, and refills from the top with pseudo-random gems. It repeats until the board is stable. Sits directly downstream of the swap stage and starts when that stage reports a move. The game controller uses `matched` to decide whether the swap must be reverted, and accumulates `cleared` into the score.

---
 rtl/game_pkg.sv | 40 ++++
 rtl/match_finder.sv | 45 ++++
 rtl/eliminate.sv | 176 +++++++++++++++++
 tb/tb_eliminate.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the match-3 board pipeline.
package game_pkg;

    localparam int N           = 8;
    localparam int NUM_COLOURS = 6;

    typedef logic [2:0] gem_t;

    localparam gem_t GEM_EMPTY = 3'd0;
    localparam gem_t GEM_RSVD  = 3'd7;

    // [row][col], row 0 is the top of the board.
    typedef gem_t [0:N-1][0:N-1] board_t;
    typedef logic [0:N-1][0:N-1] mask_t;
    typedef logic [6:0]          count_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        CLEAR = 3'd2,
        FALL  = 3'd3,
        DONE  = 3'd4
    } elim_state_t;

    // 24-bit Fibonacci LFSR, taps 24,23,22,17.
    function automatic logic [23:0] lfsr_step(input logic [23:0] v);
        return {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
    endfunction

    // Map three LFSR bits onto a colour 1..6 (value mod 6, plus one).
    function automatic gem_t refill_gem(input logic [2:0] v);
        return (v >= 3'd6) ? (v - 3'd5) : (v + 3'd1);
    endfunction

    // Only real colours can take part in a run; empty and reserved never do.
    function automatic logic is_colour(input gem_t g);
        return (g != GEM_EMPTY) && (g != GEM_RSVD);
    endfunction

endpackage

// File: rtl/match_finder.sv
// Combinational run detector: flags every cell that sits in a horizontal or
// vertical run of three or more equal colours, and counts the flagged cells.
module match_finder
    import game_pkg::*;
(
    input  board_t board,
    output mask_t  mask,
    output count_t count
);

    // Any 3-wide window of equal colours marks all three cells; longer runs
    // are covered by overlapping windows, and a cell hit both ways is marked once.
    always_comb begin
        mask = '0;
        for (int a = 0; a < N; a++) begin
            for (int b = 0; b < N - 2; b++) begin
                if (is_colour(board[a][b]) &&
                    board[a][b] == board[a][b+1] &&
                    board[a][b] == board[a][b+2]) begin
                    mask[a][b]   = 1'b1;
                    mask[a][b+1] = 1'b1;
                    mask[a][b+2] = 1'b1;
                end
                if (is_colour(board[b][a]) &&
                    board[b][a] == board[b+1][a] &&
                    board[b][a] == board[b+2][a]) begin
                    mask[b][a]   = 1'b1;
                    mask[b+1][a] = 1'b1;
                    mask[b+2][a] = 1'b1;
                end
            end
        end
    end

    // Population count of the mask (at most N*N = 64 fits in 7 bits).
    always_comb begin
        count = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                count = count + count_t'(mask[r][c]);
            end
        end
    end

endmodule

// File: rtl/eliminate.sv
// Board resolver: repeatedly finds runs, clears them, applies gravity with
// LFSR refills from the top, until no run remains or the pass cap is hit.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE (it is
// ignored otherwise); busy is high in SCAN/CLEAR/FALL; done pulses for exactly
// one cycle in DONE, and board_out/matched/cleared/chain are valid with it and
// hold until the next accepted start (board_out until the next done).
module eliminate
    import game_pkg::*;
#(
    parameter int          N        = 8,
    parameter int          MAX_PASS = 15,
    parameter logic [23:0] SEED     = 24'hACE1F3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  board_t     board_in,
    output board_t     board_out,
    output logic       busy,
    output logic       done,
    output logic       matched,
    output logic [7:0] cleared,
    output logic [3:0] chain
);

    elim_state_t state_q, state_d;
    board_t      work_q, work_d;
    board_t      board_out_q, board_out_d;
    logic        matched_q, matched_d;
    logic [7:0]  cleared_q, cleared_d;
    logic [3:0]  chain_q, chain_d;
    logic [23:0] lfsr_q, lfsr_d;

    mask_t       mask;
    count_t      pop;
    board_t      fell;
    logic        fell_empty;
    logic [8:0]  clr_sum;

    match_finder u_match_finder (
        .board (work_q),
        .mask  (mask),
        .count (pop)
    );

    assign clr_sum = {1'b0, cleared_q} + {2'b00, pop};

    // One gravity step: in every column the cells above the lowest hole move
    // down one row and row 0 takes a fresh gem from that column's LFSR slice.
    always_comb begin
        logic hole;
        int   low;
        fell = work_q;
        hole = 1'b0;
        low  = 0;
        for (int c = 0; c < N; c++) begin
            hole = 1'b0;
            low  = 0;
            for (int r = 0; r < N; r++) begin
                if (work_q[r][c] == GEM_EMPTY) begin
                    hole = 1'b1;
                    low  = r;
                end
            end
            if (hole) begin
                for (int r = 1; r < N; r++) begin
                    if (r <= low) begin
                        fell[r][c] = work_q[r-1][c];
                    end
                end
                fell[0][c] = refill_gem(lfsr_q[3*c +: 3]);
            end
        end
    end

    // Whether any hole survives this gravity step (more FALL cycles needed).
    always_comb begin
        fell_empty = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (fell[r][c] == GEM_EMPTY) begin
                    fell_empty = 1'b1;
                end
            end
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        board_out_d = board_out_q;
        matched_d   = matched_q;
        cleared_d   = cleared_q;
        chain_d     = chain_q;
        lfsr_d      = lfsr_step(lfsr_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d    = board_in;
                    matched_d = 1'b0;
                    cleared_d = '0;
                    chain_d   = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (mask == '0 || chain_q == 4'(MAX_PASS)) begin
                    // Publish on entry to DONE so the result is valid with the pulse.
                    board_out_d = work_q;
                    state_d     = DONE;
                end else begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        if (mask[r][c]) begin
                            work_d[r][c] = GEM_EMPTY;
                        end
                    end
                end
                cleared_d = (clr_sum > 9'd255) ? 8'hFF : clr_sum[7:0];
                chain_d   = chain_q + 4'd1;
                if (chain_q == 4'd0) begin
                    matched_d = 1'b1;
                end
                state_d = FALL;
            end
            FALL: begin
                work_d = fell;
                if (!fell_empty) begin
                    state_d = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            board_out_q <= '0;
            matched_q   <= 1'b0;
            cleared_q   <= '0;
            chain_q     <= '0;
            lfsr_q      <= SEED;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            board_out_q <= board_out_d;
            matched_q   <= matched_d;
            cleared_q   <= cleared_d;
            chain_q     <= chain_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign board_out = board_out_q;
    assign matched   = matched_q;
    assign cleared   = cleared_q;
    assign chain     = chain_q;
    assign busy      = (state_q == SCAN) || (state_q == CLEAR) || (state_q == FALL);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_eliminate.sv
// Self-checking bench for eliminate: directed vector table, hand-written
// multi-cycle sequences, and random boards against a behavioural model.
module tb_eliminate;
    import game_pkg::*;

    localparam int          MAXP = 15;
    localparam logic [23:0] SEED = 24'hACE1F3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    board_t     board_in = '0;
    board_t     board_out;
    logic       busy, done, matched;
    logic [7:0] cleared;
    logic [3:0] chain;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] m_lfsr;
    logic [23:0] force_val;
    board_t      exp_q[$];

    eliminate #(.N(8), .MAX_PASS(MAXP), .SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .board_in  (board_in),
        .board_out (board_out),
        .busy      (busy),
        .done      (done),
        .matched   (matched),
        .cleared   (cleared),
        .chain     (chain)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_lfsr(input logic [23:0] v);
        logic fb;
        fb = v[23] ^ v[22] ^ v[21] ^ v[16];
        return {v[22:0], fb};
    endfunction

    // Free-running copy of the LFSR sequence (advances every cycle, reset to SEED).
    always @(posedge clk) m_lfsr <= rst ? SEED : ref_lfsr(m_lfsr);

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic bit ref_colour(input gem_t g);
        return (g >= 3'd1) && (g <= 3'd6);
    endfunction

    // Maximal-run scan of every row and column; returns mask and its size.
    function automatic int find_runs(input board_t w, output logic [63:0] mk);
        int s, e, pop;
        mk = '0;
        for (int r = 0; r < N; r++) begin
            s = 0;
            while (s < N) begin
                e = s;
                while (e + 1 < N && w[r][e+1] == w[r][s]) e++;
                if (ref_colour(w[r][s]) && (e - s + 1) >= 3)
                    for (int k = s; k <= e; k++) mk[r*N + k] = 1'b1;
                s = e + 1;
            end
        end
        for (int c = 0; c < N; c++) begin
            s = 0;
            while (s < N) begin
                e = s;
                while (e + 1 < N && w[e+1][c] == w[s][c]) e++;
                if (ref_colour(w[s][c]) && (e - s + 1) >= 3)
                    for (int k = s; k <= e; k++) mk[k*N + c] = 1'b1;
                s = e + 1;
            end
        end
        pop = 0;
        for (int i = 0; i < N * N; i++) pop += int'(mk[i]);
        return pop;
    endfunction

    function automatic board_t fall_step(input board_t w, input logic [23:0] l);
        int low;
        int v;
        for (int c = 0; c < N; c++) begin
            low = -1;
            for (int r = 0; r < N; r++) if (w[r][c] == 3'd0) low = r;
            if (low >= 0) begin
                for (int r = low; r >= 1; r--) w[r][c] = w[r-1][c];
                v = int'(l[3*c +: 3]);
                w[0][c] = gem_t'((v % 6) + 1);
            end
        end
        return w;
    endfunction

    function automatic bit any_empty(input board_t w);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (w[r][c] == 3'd0) return 1'b1;
        return 1'b0;
    endfunction

    // Resolve a board pass by pass, counting cycles from the start cycle (t=0)
    // and stepping the LFSR once per cycle (held constant when forced).
    task automatic ref_resolve(input board_t b, input bit frc, input logic [23:0] fval,
                               input logic [23:0] l0, output board_t out, output bit m,
                               output int clr, output int ch, output int lat);
        board_t      w;
        logic [23:0] l;
        logic [63:0] mk;
        int          t, pop;
        w = b; l = l0; t = 0; m = 0; clr = 0; ch = 0;
        while (1) begin
            t++; l = frc ? fval : ref_lfsr(l);
            pop = find_runs(w, mk);
            if (pop == 0 || ch == MAXP) break;
            t++; l = frc ? fval : ref_lfsr(l);
            for (int i = 0; i < N * N; i++) if (mk[i]) w[i / N][i % N] = 3'd0;
            clr = (clr + pop > 255) ? 255 : clr + pop;
            if (ch == 0) m = 1;
            ch++;
            do begin
                t++; l = frc ? fval : ref_lfsr(l);
                w = fall_step(w, l);
            end while (any_empty(w));
        end
        out = w;
        lat = t + 1;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic board_t checker_board();
        board_t b;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[r][c] = ((r + c) % 2 == 0) ? 3'd1 : 3'd2;
        return b;
    endfunction

    function automatic board_t rand_board();
        board_t b;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[r][c] = gem_t'($urandom_range(1, 6));
        return b;
    endfunction

    function automatic board_t ones_board();
        board_t b;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[r][c] = 3'd1;
        return b;
    endfunction

    function automatic board_t cross_board();
        board_t b;
        b = checker_board();
        for (int c = 2; c <= 6; c++) b[4][c] = 3'd5;
        for (int r = 2; r <= 6; r++) b[r][4] = 3'd5;
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Drive one start, wait (bounded) for done, compare everything against the model.
    task automatic run_case(input string name, input board_t b, input bit frc,
                            input logic [23:0] fval, input bit inject,
                            output board_t got_board, output bit got_m,
                            output int got_clr, output int got_ch);
        board_t eb, exp_b;
        bit     em;
        int     ec, ech, elat, t;
        @(negedge clk);
        if (frc) begin
            force_val = fval;
            force dut.lfsr_q = force_val;
        end
        ref_resolve(b, frc, fval, m_lfsr, eb, em, ec, ech, elat);
        exp_q.push_back(eb);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        board_in = rand_board();
        t = 1;
        check({name, "_busy_t1"}, busy, 1'b1);
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
            start = inject && (t == 3);
            if (start) board_in = ones_board();
        end
        start = 1'b0;
        check({name, "_done_seen"}, done, 1'b1);
        check({name, "_latency"}, t, elat);
        check({name, "_busy_in_done"}, busy, 1'b0);
        exp_b = exp_q.pop_front();
        check({name, "_board"}, board_out, exp_b);
        check({name, "_matched"}, matched, em);
        check({name, "_cleared"}, cleared, ec);
        check({name, "_chain"}, chain, ech);
        got_board = board_out;
        got_m     = matched;
        got_clr   = int'(cleared);
        got_ch    = int'(chain);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 1'b0);
        if (frc) begin
            release dut.lfsr_q;
            do_reset();
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        board_t      b;
        bit          frc;
        logic [23:0] fval;
        bit          exp_matched;
        int          min_clr, max_clr;
        int          min_ch, max_ch;
        bit          chk_board;
        board_t      exp_board;
    } vec_t;

    vec_t vecs[6];

    initial begin
        board_t gb, cb, bb;
        bit     gm, seen;
        int     gc, gch;

        // 0: checkerboard, no runs
        cb = checker_board();
        vecs[0] = '{"checker", cb, 1'b0, 24'h0, 1'b0, 0, 0, 0, 0, 1'b1, cb};

        // 1: reserved (7) and empty (0) gems never form runs
        bb = checker_board();
        for (int c = 0; c <= 3; c++) bb[3][c] = 3'd7;
        for (int c = 0; c <= 2; c++) bb[5][c] = 3'd0;
        vecs[1] = '{"reserved_empty", bb, 1'b0, 24'h0, 1'b0, 0, 0, 0, 0, 1'b1, bb};

        // 2: single horizontal run on row 7; refill colours 4,5,4 in cols 0..2
        bb = checker_board();
        for (int c = 0; c <= 2; c++) bb[7][c] = 3'd3;
        gb = bb;
        for (int c = 0; c <= 2; c++)
            for (int r = 7; r >= 1; r--) gb[r][c] = bb[r-1][c];
        gb[0][0] = 3'd4; gb[0][1] = 3'd5; gb[0][2] = 3'd4;
        vecs[2] = '{"single_row", bb, 1'b1, 24'h0000E3, 1'b1, 3, 3, 1, 1, 1'b1, gb};

        // 3: cross of 9 distinct cells
        vecs[3] = '{"cross", cross_board(), 1'b0, 24'h0, 1'b1, 9, 255, 1, MAXP, 1'b0, '0};

        // 4: cascade -- first gravity step lines up 4,4,4 on row 7
        bb = checker_board();
        for (int c = 0; c <= 2; c++) bb[7][c] = 3'd3;
        bb[7][3] = 3'd4; bb[6][1] = 3'd4; bb[6][2] = 3'd4;
        vecs[4] = '{"cascade", bb, 1'b0, 24'h0, 1'b1, 6, 255, 2, MAXP, 1'b0, '0};

        // 5: all ones, refills forced to colour 1 -> pass cap and saturation
        vecs[5] = '{"cap_sat", ones_board(), 1'b1, 24'h000000, 1'b1, 255, 255, MAXP, MAXP,
                    1'b1, ones_board()};

        // reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_board_out", board_out, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_matched", matched, 1'b0);
        check("rst_cleared", cleared, 8'd0);
        check("rst_chain", chain, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_case(vecs[i].name, vecs[i].b, vecs[i].frc, vecs[i].fval, 1'b0, gb, gm, gc, gch);
            check({vecs[i].name, "_tbl_matched"}, gm, vecs[i].exp_matched);
            check_range({vecs[i].name, "_tbl_cleared"}, gc, vecs[i].min_clr, vecs[i].max_clr);
            check_range({vecs[i].name, "_tbl_chain"}, gch, vecs[i].min_ch, vecs[i].max_ch);
            if (vecs[i].chk_board) check({vecs[i].name, "_tbl_board"}, gb, vecs[i].exp_board);
        end

        // start pulsed while busy (with a different board_in) is ignored
        run_case("busy_start", cross_board(), 1'b0, 24'h0, 1'b1, gb, gm, gc, gch);
        check("busy_start_matched", gm, 1'b1);

        // results hold after done
        repeat (3) @(negedge clk);
        check("hold_cleared", cleared, gc);
        check("hold_chain", chain, gch);

        // reset asserted in FALL aborts at once
        @(negedge clk);
        board_in = cross_board();
        start    = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("fall_busy", busy, 1'b1);
        check("fall_pass1_cleared", cleared, 8'd9);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_matched", matched, 1'b0);
        check("abort_cleared", cleared, 8'd0);
        check("abort_chain", chain, 4'd0);
        check("abort_board_out", board_out, '0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        run_case("after_abort", cross_board(), 1'b0, 24'h0, 1'b0, gb, gm, gc, gch);

        // random boards against the model
        for (int i = 0; i < 20; i++) begin
            run_case($sformatf("rand%0d", i), rand_board(), 1'b0, 24'h0, 1'b0, gb, gm, gc, gch);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
